// File: rtl/stall_ctrl_pkg.sv
// Shared constants, FSM encoding and the register-hazard test for the stall controller.
package stall_ctrl_pkg;

   localparam int         MULT_LAT_DEF = 5;
   localparam int         DIV_LAT_DEF  = 10;
   localparam logic [1:0] TUSE_NONE    = 2'd3;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // Written as an if so that an unknown address or write enable falls through to "no hazard".
   function automatic logic reg_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] dst,
      input logic       we,
      input logic [1:0] tnew
   );
      logic hit;
      hit = 1'b0;
      if ((src != 5'd0) && (src == dst) && (we == 1'b1) &&
          (tuse != TUSE_NONE) && (tuse < tnew))
         hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/md_timer.sv
// Busy timer for the HI/LO unit: counts LAT cycles after a mult/div starts in E.
module md_timer
   import stall_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy
);

   md_state_t  r_state;
   md_state_t  w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= MD_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A start seen while BUSY is deliberately dropped: the unit cannot restart mid-operation.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         MD_IDLE: begin
            if (start) begin
               w_state_nxt = MD_BUSY;
               w_cnt_nxt   = is_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
            end
         end
         MD_BUSY: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1)
               w_state_nxt = MD_IDLE;
         end
         default: begin
            w_state_nxt = MD_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      busy = (r_state == MD_BUSY);
   end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: register and HI/LO hazards in D, plus a saturating stall counter.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs_addr,
   input  logic [4:0]  D_rt_addr,
   input  logic [1:0]  D_rs_tuse,
   input  logic [1:0]  D_rt_tuse,
   input  logic        D_md_use,
   input  logic [4:0]  E_reg_addr,
   input  logic        E_reg_write,
   input  logic [1:0]  E_tnew,
   input  logic [4:0]  M_reg_addr,
   input  logic        M_reg_write,
   input  logic [1:0]  M_tnew,
   input  logic        E_md_start,
   input  logic        E_md_div,
   output logic        F_en,
   output logic        D_en,
   output logic        E_clr,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);

   logic        w_md_busy;
   logic        w_rs_hazard;
   logic        w_rt_hazard;
   logic        w_md_hazard;
   logic        w_stall;
   logic [31:0] r_stall_cnt;

   md_timer #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (E_md_start),
      .is_div (E_md_div),
      .busy   (w_md_busy)
   );

   always_comb begin
      w_rs_hazard = reg_hazard(D_rs_addr, D_rs_tuse, E_reg_addr, E_reg_write, E_tnew) |
                    reg_hazard(D_rs_addr, D_rs_tuse, M_reg_addr, M_reg_write, M_tnew);
      w_rt_hazard = reg_hazard(D_rt_addr, D_rt_tuse, E_reg_addr, E_reg_write, E_tnew) |
                    reg_hazard(D_rt_addr, D_rt_tuse, M_reg_addr, M_reg_write, M_tnew);
      w_md_hazard = D_md_use & (w_md_busy | E_md_start);
      w_stall     = w_rs_hazard | w_rt_hazard | w_md_hazard;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= 32'd0;
      else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   always_comb begin
      F_en      = ~w_stall;
      D_en      = ~w_stall;
      E_clr     = w_stall;
      md_busy   = w_md_busy;
      stall_cnt = r_stall_cnt;
   end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: stimulus queues expected outputs, a monitor pops and compares.
module tb_stall_ctrl;
   import stall_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic [4:0]  D_rs_addr, D_rt_addr, E_reg_addr, M_reg_addr;
   logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
   logic        D_md_use, E_reg_write, M_reg_write, E_md_start, E_md_div;
   logic        F_en, D_en, E_clr, md_busy;
   logic [31:0] stall_cnt;

   typedef struct {
      string       name;
      logic        stall;
      logic        busy;
      logic [31:0] cnt;
   } exp_t;

   exp_t        expQ[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] expCnt = 32'd0;
   logic        sampleReq = 1'b0;

   stall_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .D_rs_addr   (D_rs_addr),
      .D_rt_addr   (D_rt_addr),
      .D_rs_tuse   (D_rs_tuse),
      .D_rt_tuse   (D_rt_tuse),
      .D_md_use    (D_md_use),
      .E_reg_addr  (E_reg_addr),
      .E_reg_write (E_reg_write),
      .E_tnew      (E_tnew),
      .M_reg_addr  (M_reg_addr),
      .M_reg_write (M_reg_write),
      .M_tnew      (M_tnew),
      .E_md_start  (E_md_start),
      .E_md_div    (E_md_div),
      .F_en        (F_en),
      .D_en        (D_en),
      .E_clr       (E_clr),
      .md_busy     (md_busy),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clearInputs();
      D_rs_addr   = 5'd0;
      D_rt_addr   = 5'd0;
      D_rs_tuse   = TUSE_NONE;
      D_rt_tuse   = TUSE_NONE;
      D_md_use    = 1'b0;
      E_reg_addr  = 5'd0;
      E_reg_write = 1'b0;
      E_tnew      = 2'd0;
      M_reg_addr  = 5'd0;
      M_reg_write = 1'b0;
      M_tnew      = 2'd0;
      E_md_start  = 1'b0;
      E_md_div    = 1'b0;
   endtask

   // Queue what this cycle should show, then move to just after the next rising edge.
   task automatic applyStimulus(input string name, input logic expStall, input logic expBusy);
      exp_t e;
      e.name  = name;
      e.stall = expStall;
      e.busy  = expBusy;
      e.cnt   = expCnt;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      if (expStall && reset)
         expCnt = expCnt + 32'd1;
   endtask

   task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkOne({e.name, " F_en"},      32'(F_en),    32'(!e.stall));
      checkOne({e.name, " D_en"},      32'(D_en),    32'(!e.stall));
      checkOne({e.name, " E_clr"},     32'(E_clr),   32'(e.stall));
      checkOne({e.name, " md_busy"},   32'(md_busy), 32'(e.busy));
      checkOne({e.name, " stall_cnt"}, stall_cnt,    e.cnt);
   endtask

   // Monitor: samples mid-cycle, or immediately when an asynchronous event is being checked.
   initial begin
      forever begin
         @(negedge clk or posedge sampleReq);
         if (expQ.size() > 0)
            checkOutput(expQ.pop_front());
      end
   end

   initial begin
      exp_t e;
      clearInputs();
      reset = 1'b1;
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus("reset", 1'b0, 1'b0);
      reset = 1'b1;

      // Load in E (tnew 2) against a tuse-1 consumer stalls; once in M (tnew 1) it no longer does.
      E_reg_addr = 5'd5; E_reg_write = 1'b1; E_tnew = 2'd2;
      D_rs_addr  = 5'd5; D_rs_tuse   = 2'd1;
      applyStimulus("loaduse_E", 1'b1, 1'b0);
      E_reg_write = 1'b0; E_tnew = 2'd0;
      M_reg_addr = 5'd5; M_reg_write = 1'b1; M_tnew = 2'd1;
      applyStimulus("loaduse_M_tuse1", 1'b0, 1'b0);

      // A tuse-0 consumer stalls in both E and M and proceeds once the load reaches W.
      clearInputs();
      E_reg_addr = 5'd5; E_reg_write = 1'b1; E_tnew = 2'd2;
      D_rs_addr  = 5'd5; D_rs_tuse   = 2'd0;
      applyStimulus("brload_E", 1'b1, 1'b0);
      E_reg_write = 1'b0; E_tnew = 2'd0;
      M_reg_addr = 5'd5; M_reg_write = 1'b1; M_tnew = 2'd1;
      applyStimulus("brload_M", 1'b1, 1'b0);
      M_reg_write = 1'b0; M_tnew = 2'd0;
      applyStimulus("brload_W", 1'b0, 1'b0);

      clearInputs();
      E_reg_addr = 5'd0; E_reg_write = 1'b1; E_tnew = 2'd2;
      D_rs_addr  = 5'd0; D_rs_tuse   = 2'd0;
      applyStimulus("zero_guard", 1'b0, 1'b0);

      clearInputs();
      E_reg_addr = 5'd7; E_reg_write = 1'b1; E_tnew = 2'd3;
      D_rt_addr  = 5'd7; D_rt_tuse   = TUSE_NONE;
      applyStimulus("rt_unused", 1'b0, 1'b0);
      D_rt_tuse = 2'd1;
      applyStimulus("rt_hazard", 1'b1, 1'b0);
      E_reg_write = 1'b0;
      applyStimulus("rt_no_write", 1'b0, 1'b0);

      clearInputs();
      M_reg_addr = 5'h13; M_reg_write = 1'b1; M_tnew = 2'd2;
      D_rs_addr  = 5'h03; D_rs_tuse   = 2'd0;
      applyStimulus("addr_msb", 1'b0, 1'b0);

      // mult followed by mfhi: 1 start cycle + 5 busy cycles of stall
      clearInputs();
      E_md_start = 1'b1; E_md_div = 1'b0; D_md_use = 1'b1;
      applyStimulus("mult_start", 1'b1, 1'b0);
      E_md_start = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus("mult_busy", 1'b1, 1'b1);
      applyStimulus("mult_done", 1'b0, 1'b0);
      D_md_use = 1'b0;

      // div with a second start at busy cycle 3 that must be ignored
      E_md_start = 1'b1; E_md_div = 1'b1;
      applyStimulus("div_start", 1'b0, 1'b0);
      E_md_start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         E_md_start = (i == 3);
         applyStimulus("div_busy", 1'b0, 1'b1);
      end
      E_md_start = 1'b0;
      applyStimulus("div_done", 1'b0, 1'b0);

      // Reset during busy cycle 4 of a div, checked before any further clock edge
      E_md_start = 1'b1; E_md_div = 1'b1;
      applyStimulus("div2_start", 1'b0, 1'b0);
      E_md_start = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus("div2_busy", 1'b0, 1'b1);
      #1 reset = 1'b0;
      expCnt = 32'd0;
      #1;
      e.name = "reset_abort"; e.stall = 1'b0; e.busy = 1'b0; e.cnt = 32'd0;
      expQ.push_back(e);
      sampleReq = 1'b1;
      #1 sampleReq = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus("in_reset", 1'b0, 1'b0);
      reset = 1'b1;
      applyStimulus("post_reset_idle", 1'b0, 1'b0);
      E_md_start = 1'b1; E_md_div = 1'b1;
      applyStimulus("div3_start", 1'b0, 1'b0);
      E_md_start = 1'b0;
      for (int i = 0; i < 10; i++) applyStimulus("div3_busy", 1'b0, 1'b1);
      applyStimulus("div3_done", 1'b0, 1'b0);

      // Register and HI/LO hazards together count once per cycle
      clearInputs();
      E_md_start = 1'b1; E_md_div = 1'b0;
      applyStimulus("mult2_start", 1'b0, 1'b0);
      E_md_start = 1'b0;
      E_reg_addr = 5'd9; E_reg_write = 1'b1; E_tnew = 2'd2;
      D_rs_addr  = 5'd9; D_rs_tuse   = 2'd0; D_md_use = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus("both_hazards", 1'b1, 1'b1);
      clearInputs();
      applyStimulus("mult2_tail", 1'b0, 1'b1);
      applyStimulus("mult2_tail", 1'b0, 1'b1);
      applyStimulus("mult2_done", 1'b0, 1'b0);

      for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
      if (expQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
